cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller that sequences a cache line fill into the 8-word-per-block data array and its tag array. On a miss it latches the block base address and issues eight word reads to the 4-cycle pipelined main memory on consecutive cycles. It steers each returning word into the data array through a one-hot word enable, then commits the tag. It sits between the cache hit/miss logic and the memory, and is shared by the I-cache and D-cache instances (one controller per cache).

## Interface
- `ADDR_W`, 16, byte-address width; word size fixed at 16 bits, 8 words (16 bytes) per block.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `miss_detected`  in  1  miss request from cache compare logic; level, sampled only in IDLE.
- `miss_address`  in  ADDR_W  byte address of the missing access.
- `mem_data_in`  in  16  word returned by memory.
- `mem_data_valid`  in  1  `mem_data_in` valid this cycle.
- `fsm_busy`  out  1  fill in progress; cache must stall.
- `mem_read_en`  out  1  read request to memory this cycle.
- `memory_address`  out  ADDR_W  word-aligned read address.
- `write_data_array`  out  1  data-array write strobe.
- `word_enable`  out  8  one-hot word select to the data array.
- `data_array_din`  out  16  data to the data array (= `mem_data_in`).
- `write_tag_array`  out  1  tag/valid write strobe, one cycle.
- `fill_done`  out  1  one-cycle pulse coincident with `write_tag_array`.

## Operation
- States: IDLE, FILL, TAGWR. Reset → IDLE; all outputs 0, `memory_address` 0, counters 0.
- **IDLE, `miss_detected`=1:**
  - latch base = {`miss_address`[ADDR_W-1:4], 4'b0};
  - clear `issue_cnt` and `recv_cnt` (3 bits each, plus a done flag each);
  - next state FILL.
- **IDLE, other inputs:** `mem_data_valid` in IDLE is ignored.
- **FILL, issue side:**
  - while issue not done, `mem_read_en`=1 and `memory_address` = base | {`issue_cnt`,1'b0};
  - `issue_cnt` increments each cycle; issue is done after count 7 is sent.
  - After that, `mem_read_en`=0 and `memory_address` holds its last value.
- **FILL, receive side:**
  - when `mem_data_valid`=1, drive `write_data_array`=1 and `word_enable` = 1<<`recv_cnt`;
  - `recv_cnt` increments. Otherwise both outputs are 0.
- **FILL exit:** on the valid that writes word 7 → TAGWR.
- **TAGWR:** `write_tag_array`=1 and `fill_done`=1 for exactly one cycle, then IDLE.
- **`fsm_busy`:** 1 in FILL and TAGWR, 0 in IDLE (decoded from state, so it rises the cycle after the miss is accepted).
- **Boundary conditions:**
  - `miss_detected` while busy is ignored; a miss held high through TAGWR is re-accepted the cycle after returning to IDLE.
  - Extra `mem_data_valid` after word 7 (TAGWR/IDLE) is ignored; no data-array write.
  - Simultaneous issue and receive in the same cycle is normal and independent.
  - Reset asserted mid-fill returns to IDLE immediately (async) and clears all outputs; a partial line is left unvalidated because no tag write occurs.
  - `word_enable` is never multi-hot and is 0 whenever `write_data_array`=0.

## Timing
- With `miss_detected` accepted at edge 0:
  - addresses are issued in cycles 1–8;
  - with memory latency L=4, data is returned in cycles 5–12;
  - TAGWR is cycle 13; `fsm_busy` is high in cycles 1–13.
- General fill latency is 8+L+1 cycles from accept to `fill_done`; the controller tolerates gaps in `mem_data_valid` (fill simply extends).
- Data-array write is combinational from `mem_data_valid` and is captured at the edge ending that cycle.
- Registered outputs: state, counters, base, `memory_address`. Combinational from state/counters/`mem_data_valid`: `write_data_array`, `word_enable`, `data_array_din`.

## Test plan
- **Basic fill:**
  - Stimulus: reset, then miss at 0x1234, with a 4-cycle memory model.
  - Required: addresses 0x1230,0x1232,…,0x123E in cycles 1–8; `word_enable` 0x01→0x80 in cycles 5–12 with data matching memory; `write_tag_array`/`fill_done` only in cycle 13; `fsm_busy` high in cycles 1–13.
- **Back-to-back misses:**
  - Stimulus: `miss_detected` held high at 0x00F0 through completion.
  - Required: second fill starts in the cycle after TAGWR, with addresses again 0x00F0–0x00FE.
- **Stalled memory:**
  - Stimulus: `mem_data_valid` drops for 3 cycles after word 3.
  - Required: no writes during the gap; words 4–7 land at 0x10,0x20,0x40,0x80; TAGWR is delayed by 3 cycles.
- **Ignored inputs:**
  - Stimulus: new miss at 0x8000 mid-fill, and a stray `mem_data_valid` in IDLE.
  - Required: base unchanged, no write, `word_enable`=0.
- **Reset mid-fill:**
  - Stimulus: `rst`=0 during word 5.
  - Required: all outputs 0 asynchronously, no tag write, IDLE after release, next miss fills cleanly from word 0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: issues eight pipelined word reads,
// steers returning words into the data array, then commits the tag.
module cache_fill_fsm #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [15:0]       mem_data_in,
    input  logic              mem_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [7:0]        word_enable,
    output logic [15:0]       data_array_din,
    output logic              write_tag_array,
    output logic              fill_done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TAGWR
    } state_t;

    localparam logic [ADDR_W-1:0] BLK_MASK =
        ~{{(ADDR_W-4){1'b0}}, 4'hF};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        issue_cnt;
    logic [2:0]        issue_nxt;
    logic              issue_done;
    logic [2:0]        recv_cnt;
    logic              accept;

    assign issue_nxt      = issue_cnt + 3'd1;
    assign data_array_din = mem_data_in;

    // Next-state and per-cycle strobes decoded from state and counters
    always_comb begin
        state_nxt        = state;
        accept           = 1'b0;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        write_data_array = 1'b0;
        word_enable      = 8'h00;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss_detected) begin
                    accept    = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                fsm_busy    = 1'b1;
                mem_read_en = ~issue_done;
                if (mem_data_valid) begin
                    write_data_array = 1'b1;
                    word_enable      = 8'h01 << recv_cnt;
                    if (recv_cnt == 3'd7)
                        state_nxt = TAGWR;
                end
            end
            TAGWR: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                fill_done       = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Block base, issue/receive counters and the registered read address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q         <= '0;
            memory_address <= '0;
            issue_cnt      <= 3'd0;
            issue_done     <= 1'b0;
            recv_cnt       <= 3'd0;
        end else if (accept) begin
            base_q         <= miss_address & BLK_MASK;
            memory_address <= miss_address & BLK_MASK;
            issue_cnt      <= 3'd0;
            issue_done     <= 1'b0;
            recv_cnt       <= 3'd0;
        end else if (state == FILL) begin
            if (!issue_done) begin
                issue_cnt <= issue_nxt;
                if (issue_cnt == 3'd7)
                    issue_done <= 1'b1;
                else
                    memory_address <= base_q |
                        {{(ADDR_W-4){1'b0}}, issue_nxt, 1'b0};
            end
            if (write_data_array)
                recv_cnt <= recv_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: pipelined memory model, behavioural
// reference model checked every cycle, plus directed literal pins.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [15:0] mem_data_in = '0;
    logic        mem_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [7:0]  word_enable;
    logic [15:0] data_array_din;
    logic        write_tag_array;
    logic        fill_done;

    cache_fill_fsm #(.ADDR_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .miss_detected(miss_detected),
        .miss_address(miss_address),
        .mem_data_in(mem_data_in),
        .mem_data_valid(mem_data_valid),
        .fsm_busy(fsm_busy),
        .mem_read_en(mem_read_en),
        .memory_address(memory_address),
        .write_data_array(write_data_array),
        .word_enable(word_enable),
        .data_array_din(data_array_din),
        .write_tag_array(write_tag_array),
        .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Behavioural model: phase 0 idle, 1 filling, 2 tag write
    int          m_phase = 0;
    logic [15:0] m_base = '0;
    logic [15:0] m_last = '0;
    int          m_issued = 0;
    int          m_recv = 0;
    int          m_rel = 100;

    logic [15:0] obs_addr [64];
    logic [7:0]  obs_we [64];
    logic        obs_rd [64];
    logic        obs_done [64];
    logic        obs_busy [64];
    int          done_cyc [$];
    int          cyc = 0;

    typedef struct {
        int          due;
        logic [15:0] a;
    } req_t;
    req_t q [$];
    req_t r;

    logic        e_rd;
    logic        e_wr;
    logic        e_tag;
    logic [15:0] e_addr;
    logic [7:0]  e_we;

    // Compare DUT against the model mid-cycle, then advance the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_busy", 32'(fsm_busy), 0);
            chk("rst_rd", 32'(mem_read_en), 0);
            chk("rst_addr", 32'(memory_address), 0);
            chk("rst_wr", 32'(write_data_array), 0);
            chk("rst_we", 32'(word_enable), 0);
            chk("rst_tag", 32'(write_tag_array), 0);
            chk("rst_done", 32'(fill_done), 0);
            m_phase  = 0;
            m_last   = '0;
            m_issued = 0;
            m_recv   = 0;
        end else begin
            e_rd   = (m_phase == 1) && (m_issued < 8);
            e_addr = e_rd ? m_base + 16'(2 * m_issued) : m_last;
            e_wr   = (m_phase == 1) && mem_data_valid;
            e_we   = e_wr ? 8'(1 << m_recv) : 8'h00;
            e_tag  = (m_phase == 2);
            chk("busy", 32'(fsm_busy), 32'(m_phase != 0));
            chk("rd_en", 32'(mem_read_en), 32'(e_rd));
            chk("addr", 32'(memory_address), 32'(e_addr));
            chk("wr", 32'(write_data_array), 32'(e_wr));
            chk("we", 32'(word_enable), 32'(e_we));
            chk("tag", 32'(write_tag_array), 32'(e_tag));
            chk("done", 32'(fill_done), 32'(e_tag));
            if (e_wr)
                chk("din", 32'(data_array_din),
                    32'(memfn(m_base + 16'(2 * m_recv))));
            if (m_rel < 64) begin
                obs_addr[m_rel] = memory_address;
                obs_we[m_rel]   = word_enable;
                obs_rd[m_rel]   = mem_read_en;
                obs_done[m_rel] = fill_done;
                obs_busy[m_rel] = fsm_busy;
            end
            if (fill_done)
                done_cyc.push_back(cyc);
            if (mem_read_en)
                q.push_back('{cyc + 4, memory_address});
            if (m_rel < 1000)
                m_rel++;
            case (m_phase)
                0: if (miss_detected) begin
                    m_base   = miss_address & 16'hFFF0;
                    m_issued = 0;
                    m_recv   = 0;
                    m_phase  = 1;
                    m_rel    = 1;
                end
                1: begin
                    if (m_issued < 8) begin
                        m_issued++;
                        if (m_issued == 8)
                            m_last = m_base + 16'd14;
                    end
                    if (mem_data_valid) begin
                        m_recv++;
                        if (m_recv == 8)
                            m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    int stall = 0;
    int delivered = 0;
    bit stall_mode = 0;
    int gap_pct = 0;
    bit stray_en = 0;

    // Four-cycle pipelined memory with optional gaps and stray valids
    always @(posedge clk) begin
        #1;
        cyc++;
        mem_data_valid = 1'b0;
        mem_data_in    = '0;
        if (!rst) begin
            q.delete();
            stall = 0;
        end else if (stall > 0) begin
            stall--;
        end else if (q.size() > 0 && q[0].due <= cyc &&
                     int'($urandom_range(99)) >= gap_pct) begin
            r = q.pop_front();
            mem_data_valid = 1'b1;
            mem_data_in    = memfn(r.a);
            delivered++;
            if (stall_mode && delivered == 4)
                stall = 3;
        end else if (stray_en && q.size() == 0 && m_phase != 1 &&
                     $urandom_range(3) == 0) begin
            mem_data_valid = 1'b1;
            mem_data_in    = 16'($urandom);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_miss(input logic [15:0] a);
        miss_address  = a;
        miss_detected = 1'b1;
        cycles(1);
        miss_detected = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        cycles(3);
        chk("init_busy", 32'(fsm_busy), 0);
        chk("init_addr", 32'(memory_address), 0);
        chk("init_tag", 32'(write_tag_array), 0);
        rst = 1'b1;
        cycles(2);

        start_miss(16'h1234);
        cycles(16);
        chk("b_addr1", 32'(obs_addr[1]), 32'h1230);
        chk("b_addr8", 32'(obs_addr[8]), 32'h123E);
        chk("b_rd8", 32'(obs_rd[8]), 1);
        chk("b_rd9", 32'(obs_rd[9]), 0);
        chk("b_we4", 32'(obs_we[4]), 0);
        chk("b_we5", 32'(obs_we[5]), 32'h01);
        chk("b_we12", 32'(obs_we[12]), 32'h80);
        chk("b_done12", 32'(obs_done[12]), 0);
        chk("b_done13", 32'(obs_done[13]), 1);
        chk("b_busy1", 32'(obs_busy[1]), 1);
        chk("b_busy13", 32'(obs_busy[13]), 1);
        chk("b_busy14", 32'(obs_busy[14]), 0);

        stray_en = 1;
        start_miss(16'h4442);
        cycles(2);
        miss_address  = 16'h8000;
        miss_detected = 1'b1;
        cycles(2);
        miss_detected = 1'b0;
        cycles(20);
        stray_en = 0;
        chk("ig_addr8", 32'(obs_addr[8]), 32'h444E);
        chk("ig_done13", 32'(obs_done[13]), 1);
        cycles(2);

        delivered  = 0;
        stall_mode = 1;
        start_miss(16'h2A50);
        cycles(20);
        stall_mode = 0;
        chk("s_we8", 32'(obs_we[8]), 32'h08);
        chk("s_we10", 32'(obs_we[10]), 0);
        chk("s_we12", 32'(obs_we[12]), 32'h10);
        chk("s_we13", 32'(obs_we[13]), 32'h20);
        chk("s_we14", 32'(obs_we[14]), 32'h40);
        chk("s_we15", 32'(obs_we[15]), 32'h80);
        chk("s_done13", 32'(obs_done[13]), 0);
        chk("s_done16", 32'(obs_done[16]), 1);

        done_cyc.delete();
        miss_address  = 16'h00F0;
        miss_detected = 1'b1;
        cycles(28);
        miss_detected = 1'b0;
        cycles(5);
        chk("bb_count", 32'(done_cyc.size()), 2);
        if (done_cyc.size() == 2)
            chk("bb_gap", 32'(done_cyc[1] - done_cyc[0]), 14);
        chk("bb_addr1", 32'(obs_addr[1]), 32'h00F0);
        chk("bb_addr8", 32'(obs_addr[8]), 32'h00FE);

        done_cyc.delete();
        start_miss(16'h5678);
        cycles(8);
        rst = 1'b0;
        #1;
        chk("mr_busy", 32'(fsm_busy), 0);
        chk("mr_addr", 32'(memory_address), 0);
        chk("mr_we", 32'(word_enable), 0);
        cycles(2);
        rst = 1'b1;
        chk("mr_notag", 32'(done_cyc.size()), 0);
        cycles(2);
        start_miss(16'h5678);
        cycles(16);
        chk("mr_addr1", 32'(obs_addr[1]), 32'h5670);
        chk("mr_we5", 32'(obs_we[5]), 32'h01);
        chk("mr_done13", 32'(obs_done[13]), 1);
        chk("mr_count", 32'(done_cyc.size()), 1);

        gap_pct  = 20;
        stray_en = 1;
        for (int i = 0; i < 40; i++) begin
            miss_detected = 1'b1;
            for (int j = 0; j < int'($urandom_range(1, 20)); j++) begin
                miss_address = 16'($urandom);
                cycles(1);
            end
            miss_detected = 1'b0;
            cycles(int'($urandom_range(0, 25)));
        end
        gap_pct = 0;
        cycles(40);
        stray_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
